switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//   Cleans a raw, bouncing push-button or slide-switch input into a stable level.
//   It sits directly upstream of the D flip-flop stage and drives that stage's D input.
//   Also emits one-cycle rise/fall strobes for downstream counters and registers.
//   Contents: 2-flop synchronizer, 4-state FSM, saturating stability counter.
// PARAMETERS
//   STABLE_COUNT  50000  consecutive synchronized samples needed to accept a new level (>=2)
//   CNT_WIDTH     16     stability counter width; must satisfy 2**CNT_WIDTH > STABLE_COUNT-1
// PORTS
//   Clk         input   1  system clock; all state updates on posedge
//   Reset       input   1  asynchronous, active-low reset (0 = reset)
//   Btn_In      input   1  raw asynchronous switch input, may bounce
//   D_Out       output  1  debounced level; feeds the flip-flop stage D
//   Rise_Pulse  output  1  high for exactly 1 cycle when D_Out goes 0->1
//   Fall_Pulse  output  1  high for exactly 1 cycle when D_Out goes 1->0
//   Busy        output  1  high while a level change is pending (FSM in a PEND state)
// BEHAVIOUR
//   Reset (Reset==0, takes effect immediately, no clock edge needed):
//     sync flops=0, cnt=0, state=STABLE_LO, D_Out=0, Rise_Pulse=0, Fall_Pulse=0, Busy=0.
//   Synchronizer: s1<=Btn_In, s2<=s1; btn_sync=s2. Btn_In is never used elsewhere.
//   FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. All outputs are registered.
//   STABLE_LO: btn_sync=1 -> PEND_HI, cnt<=1; else stay, cnt<=0.
//   PEND_HI:   btn_sync=0 -> STABLE_LO, cnt<=0 (bounce; count discarded, no output change).
//              btn_sync=1 & cnt==STABLE_COUNT-1 -> STABLE_HI, D_Out<=1, Rise_Pulse<=1, cnt<=0.
//              btn_sync=1 otherwise -> cnt<=cnt+1.
//   STABLE_HI / PEND_LO: mirror image (btn_sync=0 counts; commit sets D_Out<=0, Fall_Pulse<=1).
//   Busy<=1 iff next state is PEND_HI or PEND_LO.
//   Rise_Pulse/Fall_Pulse are cleared on every edge that is not a commit edge; never both high.
//   Latency: Btn_In first sampled high at edge k, then held. D_Out=1 after edge k+STABLE_COUNT+1.
//     Rise_Pulse is high for that same single cycle.
//   Counter never exceeds STABLE_COUNT-1 and never wraps.
//   A mismatch lasting fewer than STABLE_COUNT samples leaves D_Out and the pulses untouched.
//   Reset mid-PEND: pending count is lost; outputs go to reset values asynchronously.
//   Reset released with Btn_In=1: D_Out starts 0, then rises via normal debounce.
//     Rise_Pulse does fire in this case.
//   Reset deassertion is assumed synchronized externally; no internal reset synchronizer.
// TESTING (STABLE_COUNT=4, CNT_WIDTH=3; edges numbered from reset release = edge 0)
//   1 Reset=0 for 3 cycles, Btn_In=1 -> all outputs 0 during reset, with no clock edge required.
//   2 Clean press: Btn_In=1 before edge 10 -> Busy=1 after edges 12..14.
//     D_Out=1 and Rise_Pulse=1 after edge 15; Rise_Pulse=0 after edge 16.
//   3 Bounce: Btn_In 1,1,0,1,1,1,1... from edge 10 -> cnt restarts at the 0.
//     D_Out stays 0 until 4 consecutive synced 1s; no extra pulses.
//   4 Release from D_Out=1: Btn_In=0 before edge 30 -> D_Out=0 and Fall_Pulse=1 after edge 35.
//     Rise_Pulse stays 0 throughout.
//   5 Reset=0 asynchronously mid-cycle while in PEND_HI with cnt=2.
//     Busy and D_Out go 0 before the next edge; after release, a full 4-sample count is required.
//   6 One-cycle glitch: Btn_In=1 for 1 cycle only -> Busy high 1 cycle.
//     D_Out, Rise_Pulse and Fall_Pulse remain 0.

Source files
------------

// File: rtl/switch_debouncer.sv
// Switch debouncer: 2-flop synchronizer feeding a 4-state FSM with a stability
// counter. A new level is accepted only after STABLE_COUNT consecutive agreeing
// synchronized samples. It emits a registered level plus one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int unsigned STABLE_COUNT = 50000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_In,
  output logic D_Out,
  output logic Rise_Pulse,
  output logic Fall_Pulse,
  output logic Busy
);

  typedef enum logic [1:0] {
    StStableLo,
    StPendHi,
    StStableHi,
    StPendLo
  } state_e;

  // Count value on which a pending level is committed.
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_COUNT - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 s1_q, s2_q;
  logic                 d_out_q, d_out_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 busy_q, busy_d;
  logic                 btn_sync;

  assign btn_sync = s2_q;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_out_d = d_out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (btn_sync) begin
          state_d = StPendHi;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPendHi: begin
        if (!btn_sync) begin
          // Bounce: the partial count is discarded.
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          d_out_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StStableHi: begin
        if (!btn_sync) begin
          state_d = StPendLo;
          cnt_d   = CNT_WIDTH'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPendLo: begin
        if (btn_sync) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
          d_out_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    endcase
    busy_d = (state_d == StPendHi) || (state_d == StPendLo);
  end

  // All state and outputs, asynchronously cleared by an active-low Reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= StStableLo;
      cnt_q   <= '0;
      d_out_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= Btn_In;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_out_q <= d_out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign D_Out      = d_out_q;
  assign Rise_Pulse = rise_q;
  assign Fall_Pulse = fall_q;
  assign Busy       = busy_q;

endmodule
